// File: rtl/main_fsm.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and write enables, counts retired instructions.
module main_fsm #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       op,
   input  logic             zero,
   input  logic             mem_ready,
   output logic [1:0]       ALUOp,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ResultSrc,
   output logic             AdrSrc,
   output logic [1:0]       ImmSrc,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             illegal,
   output logic [CNT_W-1:0] instret,
   output logic [3:0]       state
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECUTEI = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] instret_q;
   logic             retire;

   // Enables before the reset override
   logic irwrite_c, pcwrite_c, regwrite_c, memwrite_c, illegal_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         if (retire) begin
            instret_q <= instret_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ALUOp      = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      AdrSrc     = 1'b0;
      irwrite_c  = 1'b0;
      pcwrite_c  = 1'b0;
      regwrite_c = 1'b0;
      memwrite_c = 1'b0;
      illegal_c  = 1'b0;
      retire     = 1'b0;

      case (state_q)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            irwrite_c = mem_ready;
            pcwrite_c = mem_ready;
            state_d   = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECUTER;
               OP_ITYPE:          state_d = S_EXECUTEI;
               OP_JAL:            state_d = S_JAL;
               OP_BEQ:            state_d = S_BEQ;
               default: begin
                  state_d   = S_FETCH;
                  illegal_c = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            AdrSrc  = 1'b1;
            state_d = mem_ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            ResultSrc  = 2'b01;
            regwrite_c = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            // MemWrite is held for the whole handshake, retire only on completion
            AdrSrc     = 1'b1;
            memwrite_c = 1'b1;
            retire     = mem_ready;
            state_d    = mem_ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECUTER: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
            state_d = S_ALUWB;
         end
         S_EXECUTEI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            regwrite_c = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_JAL: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pcwrite_c = 1'b1;
            state_d   = S_ALUWB;
         end
         S_BEQ: begin
            ALUSrcA   = 2'b10;
            ALUOp     = 2'b01;
            pcwrite_c = zero;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   always_comb begin
      case (op)
         OP_STORE: ImmSrc = 2'b01;
         OP_BEQ:   ImmSrc = 2'b10;
         OP_JAL:   ImmSrc = 2'b11;
         default:  ImmSrc = 2'b00;
      endcase
   end

   // Reset masks every side-effecting output regardless of the current state
   assign IRWrite  = irwrite_c  & ~reset;
   assign PCWrite  = pcwrite_c  & ~reset;
   assign RegWrite = regwrite_c & ~reset;
   assign MemWrite = memwrite_c & ~reset;
   assign illegal  = illegal_c  & ~reset;

   assign instret = instret_q;
   assign state   = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: directed vector table, then random instruction stream
// checked against an instruction-level path model.
module tb_main_fsm;

   localparam int CW = 4;

   localparam logic [6:0] LW   = 7'b0000011;
   localparam logic [6:0] SW   = 7'b0100011;
   localparam logic [6:0] RT   = 7'b0110011;
   localparam logic [6:0] IT   = 7'b0010011;
   localparam logic [6:0] JL   = 7'b1101111;
   localparam logic [6:0] BQ   = 7'b1100011;
   localparam logic [6:0] ILL0 = 7'b0000000;

   logic          clk = 1'b0;
   logic          reset;
   logic [6:0]    op;
   logic          zero;
   logic          mem_ready;
   logic [1:0]    ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
   logic          AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal;
   logic [CW-1:0] instret;
   logic [3:0]    state;

   int n_checks = 0;
   int n_fail   = 0;

   main_fsm #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
      .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .AdrSrc(AdrSrc), .ImmSrc(ImmSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .RegWrite(RegWrite), .MemWrite(MemWrite), .illegal(illegal),
      .instret(instret), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic [6:0]    op;
      logic          zero;
      logic          mr;
      logic [3:0]    st;
      logic [4:0]    en;     // {IRWrite, PCWrite, RegWrite, MemWrite, illegal}
      logic [1:0]    aluop;
      logic [CW-1:0] inst;
   } vec_t;

   vec_t vecs[40];
   int   nv = 0;

   typedef struct {
      logic [3:0] st;
      logic       mr;
      logic       zero;
   } step_t;

   step_t plan[$];

   task automatic add(input logic rst, input logic [6:0] o, input logic z, input logic mr,
                      input logic [3:0] st, input logic [4:0] en, input logic [1:0] aluop,
                      input logic [CW-1:0] inst);
      vecs[nv] = '{rst, o, z, mr, st, en, aluop, inst};
      nv++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic is_legal(input logic [6:0] o);
      return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == JL) || (o == BQ);
   endfunction

   function automatic logic [1:0] imm_of(input logic [6:0] o);
      if (o == SW) return 2'b01;
      if (o == BQ) return 2'b10;
      if (o == JL) return 2'b11;
      return 2'b00;
   endfunction

   // {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ImmSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal}
   function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic mr,
                                            input logic z, input logic [6:0] o);
      logic [1:0] aop = 2'b00, sa = 2'b00, sb = 2'b00, rs = 2'b00;
      logic       adr = 1'b0, irw = 1'b0, pcw = 1'b0, rw = 1'b0, mw = 1'b0, ill = 1'b0;
      case (st)
         4'd0:  begin sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
         4'd1:  begin sa = 2'b01; sb = 2'b01; ill = !is_legal(o); end
         4'd2:  begin sa = 2'b10; sb = 2'b01; end
         4'd3:  adr = 1'b1;
         4'd4:  begin rs = 2'b01; rw = 1'b1; end
         4'd5:  begin adr = 1'b1; mw = 1'b1; end
         4'd6:  begin sa = 2'b10; aop = 2'b10; end
         4'd7:  rw = 1'b1;
         4'd8:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
         4'd9:  begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
         4'd10: begin sa = 2'b10; aop = 2'b01; pcw = z; end
         default: ;
      endcase
      return {aop, sa, sb, rs, adr, imm_of(o), irw, pcw, rw, mw, ill};
   endfunction

   function automatic step_t mk(input logic [3:0] st, input logic mr);
      step_t s;
      s.st   = st;
      s.mr   = mr;
      s.zero = 1'(($urandom) & 1);
      return s;
   endfunction

   initial begin
      logic [6:0]    rop;
      logic [CW-1:0] inst_exp;
      logic          retires;
      int            k, ncyc;

      reset = 1'b1; op = RT; zero = 1'b0; mem_ready = 1'b1;

      // Reset, R-type, stalled lw, stalled sw, beq taken/not taken, illegal,
      // reset in ALUWB, fetch stall after reset
      add(1, RT, 0, 1,  0, 5'b00000, 2'b00, 0);
      add(1, RT, 0, 1,  0, 5'b00000, 2'b00, 0);
      add(0, RT, 0, 1,  0, 5'b11000, 2'b00, 0);
      add(0, RT, 0, 1,  1, 5'b00000, 2'b00, 0);
      add(0, RT, 0, 1,  6, 5'b00000, 2'b10, 0);
      add(0, RT, 0, 1,  7, 5'b00100, 2'b00, 0);
      add(0, LW, 0, 1,  0, 5'b11000, 2'b00, 1);
      add(0, LW, 0, 1,  1, 5'b00000, 2'b00, 1);
      add(0, LW, 0, 1,  2, 5'b00000, 2'b00, 1);
      add(0, LW, 0, 0,  3, 5'b00000, 2'b00, 1);
      add(0, LW, 0, 0,  3, 5'b00000, 2'b00, 1);
      add(0, LW, 0, 0,  3, 5'b00000, 2'b00, 1);
      add(0, LW, 0, 1,  3, 5'b00000, 2'b00, 1);
      add(0, LW, 0, 1,  4, 5'b00100, 2'b00, 1);
      add(0, SW, 0, 1,  0, 5'b11000, 2'b00, 2);
      add(0, SW, 0, 1,  1, 5'b00000, 2'b00, 2);
      add(0, SW, 0, 1,  2, 5'b00000, 2'b00, 2);
      add(0, SW, 0, 0,  5, 5'b00010, 2'b00, 2);
      add(0, SW, 0, 0,  5, 5'b00010, 2'b00, 2);
      add(0, SW, 0, 1,  5, 5'b00010, 2'b00, 2);
      add(0, BQ, 1, 1,  0, 5'b11000, 2'b00, 3);
      add(0, BQ, 1, 1,  1, 5'b00000, 2'b00, 3);
      add(0, BQ, 1, 1, 10, 5'b01000, 2'b01, 3);
      add(0, BQ, 0, 1,  0, 5'b11000, 2'b00, 4);
      add(0, BQ, 0, 1,  1, 5'b00000, 2'b00, 4);
      add(0, BQ, 0, 1, 10, 5'b00000, 2'b01, 4);
      add(0, ILL0, 0, 1, 0, 5'b11000, 2'b00, 5);
      add(0, ILL0, 0, 1, 1, 5'b00001, 2'b00, 5);
      add(0, RT, 0, 1,  0, 5'b11000, 2'b00, 5);
      add(0, RT, 0, 1,  1, 5'b00000, 2'b00, 5);
      add(0, RT, 0, 1,  6, 5'b00000, 2'b10, 5);
      add(1, RT, 0, 1,  7, 5'b00000, 2'b00, 5);
      add(0, RT, 0, 0,  0, 5'b00000, 2'b00, 0);
      add(0, RT, 0, 1,  0, 5'b11000, 2'b00, 0);

      repeat (2) @(posedge clk);

      for (int i = 0; i < nv; i++) begin
         @(negedge clk);
         reset = vecs[i].rst; op = vecs[i].op; zero = vecs[i].zero; mem_ready = vecs[i].mr;
         #1;
         check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].st));
         check($sformatf("vec%0d enables", i),
               32'({IRWrite, PCWrite, RegWrite, MemWrite, illegal}), 32'(vecs[i].en));
         check($sformatf("vec%0d ALUOp", i), 32'(ALUOp), 32'(vecs[i].aluop));
         check($sformatf("vec%0d instret", i), 32'(instret), 32'(vecs[i].inst));
         $display("vec %0d: rst=%0b op=%b state=%0d instret=%0d", i, reset, op, state, instret);
      end

      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      inst_exp = '0;

      for (int n = 0; n < 300; n++) begin
         k = $urandom_range(0, 6);
         case (k)
            0: rop = LW;
            1: rop = SW;
            2: rop = RT;
            3: rop = IT;
            4: rop = JL;
            5: rop = BQ;
            default: begin
               do rop = 7'($urandom_range(0, 127)); while (is_legal(rop));
            end
         endcase

         plan.delete();
         repeat ($urandom_range(0, 2)) plan.push_back(mk(4'd0, 1'b0));
         plan.push_back(mk(4'd0, 1'b1));
         plan.push_back(mk(4'd1, 1'($urandom & 1)));
         retires = 1'b1;
         case (k)
            0: begin
               plan.push_back(mk(4'd2, 1'($urandom & 1)));
               repeat ($urandom_range(0, 3)) plan.push_back(mk(4'd3, 1'b0));
               plan.push_back(mk(4'd3, 1'b1));
               plan.push_back(mk(4'd4, 1'($urandom & 1)));
            end
            1: begin
               plan.push_back(mk(4'd2, 1'($urandom & 1)));
               repeat ($urandom_range(0, 3)) plan.push_back(mk(4'd5, 1'b0));
               plan.push_back(mk(4'd5, 1'b1));
            end
            2: begin
               plan.push_back(mk(4'd6, 1'($urandom & 1)));
               plan.push_back(mk(4'd7, 1'($urandom & 1)));
            end
            3: begin
               plan.push_back(mk(4'd8, 1'($urandom & 1)));
               plan.push_back(mk(4'd7, 1'($urandom & 1)));
            end
            4: begin
               plan.push_back(mk(4'd9, 1'($urandom & 1)));
               plan.push_back(mk(4'd7, 1'($urandom & 1)));
            end
            5: plan.push_back(mk(4'd10, 1'($urandom & 1)));
            default: retires = 1'b0;
         endcase

         ncyc = plan.size();
         foreach (plan[j]) begin
            @(negedge clk);
            op = rop; zero = plan[j].zero; mem_ready = plan[j].mr;
            #1;
            check($sformatf("rnd%0d.%0d state", n, j), 32'(state), 32'(plan[j].st));
            check($sformatf("rnd%0d.%0d ctrl", n, j),
                  32'({ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ImmSrc,
                       IRWrite, PCWrite, RegWrite, MemWrite, illegal}),
                  32'(exp_ctrl(plan[j].st, plan[j].mr, plan[j].zero, rop)));
            check($sformatf("rnd%0d.%0d instret", n, j), 32'(instret), 32'(inst_exp));
         end
         if (retires) inst_exp = inst_exp + 1'b1;
         $display("instr %0d: op=%b cycles=%0d retire=%0b instret_model=%0d",
                  n, rop, ncyc, retires, inst_exp);
      end

      @(negedge clk);
      #1;
      check("final state", 32'(state), 32'd0);
      check("final instret", 32'(instret), 32'(inst_exp));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
